// File: rtl/e203_exu_flush_sched.sv
// ---------------------------------------------------------------------------
// e203_exu_flush_sched
//
// Flush scheduler for the EXU commit stage. Arbitrates between the
// exception/interrupt flush source and the branch-resolve flush source,
// registers the winner's adder operands and holds them as a single request
// to the IFU until it is acknowledged. A minimum idle gap is inserted after
// every completed flush, and saturating per-source counters record how many
// flushes each source completed.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   excp_req_i/op1/op2, ack_o   exception flush source (higher priority)
//   brch_req_i/op1/op2, ack_o   branch-mispredict flush source
//   pipe_flush_req_o/op1/op2    registered flush request towards the IFU
//   pipe_flush_ack_i            IFU accepts the flush
//   flush_pulse_o               flush completed this cycle
//   brch_kill_o                 held branch flush replaced by an exception
//   busy_o                      scheduler not idle
//   excp_cnt_o, brch_cnt_o      completed flushes per source (saturating)
//   cnt_clr_i                   clear both counters
//
// Handshakes: a source raises req and holds req/ops stable until it sees
// its ack high in a cycle; the transfer happens in that cycle and the source
// drops req on the following cycle. Acks are combinational from the current
// state and the request inputs. Towards the IFU, pipe_flush_req_o is held
// with stable ops until the cycle pipe_flush_ack_i is sampled high.
// ---------------------------------------------------------------------------
module e203_exu_flush_sched #(
    parameter int PC_SIZE = 32,
    parameter int GAP_CYC = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               excp_req_i,
    input  logic [PC_SIZE-1:0] excp_op1_i,
    input  logic [PC_SIZE-1:0] excp_op2_i,
    output logic               excp_ack_o,
    input  logic               brch_req_i,
    input  logic [PC_SIZE-1:0] brch_op1_i,
    input  logic [PC_SIZE-1:0] brch_op2_i,
    output logic               brch_ack_o,
    output logic               pipe_flush_req_o,
    output logic [PC_SIZE-1:0] pipe_flush_op1_o,
    output logic [PC_SIZE-1:0] pipe_flush_op2_o,
    input  logic               pipe_flush_ack_i,
    output logic               flush_pulse_o,
    output logic               brch_kill_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   excp_cnt_o,
    output logic [CNT_W-1:0]   brch_cnt_o,
    input  logic               cnt_clr_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef enum logic {
        SRC_EXCP = 1'b0,
        SRC_BRCH = 1'b1
    } src_e;

    // Gap counter load value; counting down to zero gives GAP_CYC idle cycles.
    localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    src_e               src_q, src_d;
    logic [PC_SIZE-1:0] op1_q, op1_d;
    logic [PC_SIZE-1:0] op2_q, op2_d;
    logic [3:0]         gap_q, gap_d;
    logic [CNT_W-1:0]   excp_cnt_q, brch_cnt_q;

    logic excp_ack_c, brch_ack_c, kill_c, pulse_c;
    logic excp_inc, brch_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= SRC_EXCP;
            op1_q   <= '0;
            op2_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        gap_d      = gap_q;
        excp_ack_c = 1'b0;
        brch_ack_c = 1'b0;
        kill_c     = 1'b0;
        pulse_c    = 1'b0;
        excp_inc   = 1'b0;
        brch_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (excp_req_i) begin
                    excp_ack_c = 1'b1;
                    op1_d      = excp_op1_i;
                    op2_d      = excp_op2_i;
                    src_d      = SRC_EXCP;
                    state_d    = ST_REQ;
                end else if (brch_req_i) begin
                    brch_ack_c = 1'b1;
                    op1_d      = brch_op1_i;
                    op2_d      = brch_op2_i;
                    src_d      = SRC_BRCH;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (pipe_flush_ack_i) begin
                    // Completion beats preemption: a branch flush acked by
                    // the IFU is done and counted even if an exception
                    // arrives in the same cycle.
                    pulse_c  = 1'b1;
                    excp_inc = (src_q == SRC_EXCP);
                    brch_inc = (src_q == SRC_BRCH);
                    if (GAP_CYC > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (src_q == SRC_BRCH && excp_req_i) begin
                    // Exception replaces the pending branch flush in place;
                    // the request line to the IFU stays high throughout.
                    excp_ack_c = 1'b1;
                    kill_c     = 1'b1;
                    op1_d      = excp_op1_i;
                    op2_d      = excp_op2_i;
                    src_d      = SRC_EXCP;
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            excp_cnt_q <= '0;
            brch_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            excp_cnt_q <= '0;
            brch_cnt_q <= '0;
        end else begin
            if (excp_inc && rst_n && excp_cnt_q != CNT_MAX) begin
                excp_cnt_q <= excp_cnt_q + CNT_W'(1);
            end
            if (brch_inc && rst_n && brch_cnt_q != CNT_MAX) begin
                brch_cnt_q <= brch_cnt_q + CNT_W'(1);
            end
        end
    end

    // Nothing is handed over while reset is being applied, so a source never
    // sees an ack for a request the scheduler is about to forget.
    assign excp_ack_o       = excp_ack_c & rst_n;
    assign brch_ack_o       = brch_ack_c & rst_n;
    assign brch_kill_o      = kill_c & rst_n;
    assign flush_pulse_o    = pulse_c & rst_n;
    assign pipe_flush_req_o = (state_q == ST_REQ);
    assign pipe_flush_op1_o = op1_q;
    assign pipe_flush_op2_o = op2_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign excp_cnt_o       = excp_cnt_q;
    assign brch_cnt_o       = brch_cnt_q;

endmodule

// File: tb/tb_e203_exu_flush_sched.sv
module tb_e203_exu_flush_sched;

  logic        clk;
  logic        rst_n;
  logic        excp_req;
  logic [31:0] excp_op1, excp_op2;
  logic        brch_req;
  logic [31:0] brch_op1, brch_op2;
  logic        pipe_ack;
  logic        cnt_clr;

  logic        excp_ack, brch_ack, req, pulse, kill, busy;
  logic [31:0] op1, op2;
  logic [15:0] excp_cnt, brch_cnt;

  logic        s_excp_ack, s_brch_ack, s_req, s_pulse, s_kill, s_busy;
  logic [31:0] s_op1, s_op2;
  logic [3:0]  s_excp_cnt, s_brch_cnt;

  int n_checks;
  int n_errors;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  e203_exu_flush_sched #(.PC_SIZE(32), .GAP_CYC(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .excp_req_i(excp_req), .excp_op1_i(excp_op1), .excp_op2_i(excp_op2),
    .excp_ack_o(excp_ack),
    .brch_req_i(brch_req), .brch_op1_i(brch_op1), .brch_op2_i(brch_op2),
    .brch_ack_o(brch_ack),
    .pipe_flush_req_o(req), .pipe_flush_op1_o(op1), .pipe_flush_op2_o(op2),
    .pipe_flush_ack_i(pipe_ack),
    .flush_pulse_o(pulse), .brch_kill_o(kill), .busy_o(busy),
    .excp_cnt_o(excp_cnt), .brch_cnt_o(brch_cnt), .cnt_clr_i(cnt_clr)
  );

  // Narrow-counter copy sharing all inputs, used to reach saturation quickly.
  e203_exu_flush_sched #(.PC_SIZE(32), .GAP_CYC(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .excp_req_i(excp_req), .excp_op1_i(excp_op1), .excp_op2_i(excp_op2),
    .excp_ack_o(s_excp_ack),
    .brch_req_i(brch_req), .brch_op1_i(brch_op1), .brch_op2_i(brch_op2),
    .brch_ack_o(s_brch_ack),
    .pipe_flush_req_o(s_req), .pipe_flush_op1_o(s_op1), .pipe_flush_op2_o(s_op2),
    .pipe_flush_ack_i(pipe_ack),
    .flush_pulse_o(s_pulse), .brch_kill_o(s_kill), .busy_o(s_busy),
    .excp_cnt_o(s_excp_cnt), .brch_cnt_o(s_brch_cnt), .cnt_clr_i(cnt_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_cnts();
    cyc(); cnt_clr = 1'b1;
    cyc(); cnt_clr = 1'b0; settle();
    chk("clr_excp_cnt", 64'(excp_cnt), 64'h0);
    chk("clr_brch_cnt", 64'(brch_cnt), 64'h0);
  endtask

  // One branch flush acked by the IFU one cycle after req rises; returns
  // in the GAP cycle that follows completion.
  task automatic brch_flush(input logic clr_at_ack);
    cyc(); brch_req = 1'b1; brch_op1 = 32'h0000_0700; brch_op2 = 32'h0000_001C; settle();
    chk("bf_brch_ack", 64'(brch_ack), 64'h1);
    chk("bf_sat_brch_ack", 64'(s_brch_ack), 64'h1);
    cyc(); brch_req = 1'b0; pipe_ack = 1'b1; cnt_clr = clr_at_ack; settle();
    chk("bf_op1", 64'(op1), 64'h700);
    chk("bf_sat_op", 64'({s_op1, s_op2}), {32'h700, 32'h1C});
    chk("bf_pulse", 64'(pulse), 64'h1);
    chk("bf_sat_req_pulse", 64'({s_req, s_pulse, s_kill, s_excp_ack}), 64'b1100);
    cyc(); pipe_ack = 1'b0; cnt_clr = 1'b0; settle();
    chk("bf_gap_busy", 64'({busy, s_busy, req}), 64'b110);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; excp_req = 1'b0; brch_req = 1'b0; pipe_ack = 1'b0; cnt_clr = 1'b0;
    excp_op1 = '0; excp_op2 = '0; brch_op1 = '0; brch_op2 = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; settle();
    chk("rst_req", 64'(req), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ops", 64'({op1, op2}), 64'h0);
    chk("rst_cnts", 64'({excp_cnt, brch_cnt}), 64'h0);
    chk("rst_pulses", 64'({excp_ack, brch_ack, pulse, kill}), 64'h0);

    // single branch flush
    cyc(); brch_req = 1'b1; brch_op1 = 32'h8000_0000; brch_op2 = 32'h10; settle();
    chk("t1_brch_ack", 64'(brch_ack), 64'h1);
    chk("t1_excp_ack", 64'(excp_ack), 64'h0);
    chk("t1_req_not_yet", 64'(req), 64'h0);
    cyc(); brch_req = 1'b0; settle();
    chk("t1_req_c3", 64'(req), 64'h1);
    chk("t1_ops", 64'({op1, op2}), {32'h8000_0000, 32'h10});
    chk("t1_busy_c3", 64'(busy), 64'h1);
    cyc(); settle();
    chk("t1_req_c4", 64'(req), 64'h1);
    cyc(); pipe_ack = 1'b1; settle();
    chk("t1_req_c5", 64'(req), 64'h1);
    chk("t1_pulse", 64'(pulse), 64'h1);
    cyc(); pipe_ack = 1'b0; settle();
    chk("t1_req_drop", 64'(req), 64'h0);
    chk("t1_busy_gap", 64'(busy), 64'h1);
    chk("t1_pulse_drop", 64'(pulse), 64'h0);
    chk("t1_brch_cnt", 64'(brch_cnt), 64'h1);
    cyc(); settle();
    chk("t1_idle", 64'(busy), 64'h0);

    // simultaneous requests
    clear_cnts();
    cyc(); excp_req = 1'b1; excp_op1 = 32'h200; excp_op2 = 32'h4;
    brch_req = 1'b1; brch_op1 = 32'h300; brch_op2 = 32'h8; settle();
    chk("t2_excp_ack", 64'(excp_ack), 64'h1);
    chk("t2_brch_no_ack", 64'(brch_ack), 64'h0);
    cyc(); excp_req = 1'b0; pipe_ack = 1'b1; settle();
    chk("t2_excp_ops", 64'({op1, op2}), {32'h200, 32'h4});
    chk("t2_excp_pulse", 64'(pulse), 64'h1);
    chk("t2_brch_no_ack_req", 64'(brch_ack), 64'h0);
    cyc(); pipe_ack = 1'b0; settle();
    chk("t2_gap", 64'({busy, req, brch_ack}), 64'b100);
    chk("t2_excp_cnt", 64'(excp_cnt), 64'h1);
    cyc(); settle();
    chk("t2_brch_ack_after_gap", 64'(brch_ack), 64'h1);
    cyc(); brch_req = 1'b0; pipe_ack = 1'b1; settle();
    chk("t2_brch_ops", 64'({op1, op2}), {32'h300, 32'h8});
    chk("t2_brch_pulse", 64'(pulse), 64'h1);
    cyc(); pipe_ack = 1'b0; settle();
    chk("t2_cnts", 64'({excp_cnt, brch_cnt}), {16'h1, 16'h1});
    cyc();

    // preemption
    clear_cnts();
    cyc(); brch_req = 1'b1; brch_op1 = 32'h400; brch_op2 = 32'hC; settle();
    chk("t3_brch_ack", 64'(brch_ack), 64'h1);
    cyc(); brch_req = 1'b0; settle();
    chk("t3_brch_ops", 64'({req, op1}), {32'h1, 32'h400});
    cyc(); excp_req = 1'b1; excp_op1 = 32'h100; excp_op2 = 32'h0; settle();
    chk("t3_excp_ack", 64'(excp_ack), 64'h1);
    chk("t3_kill", 64'(kill), 64'h1);
    chk("t3_ops_old", 64'({req, op1}), {32'h1, 32'h400});
    cyc(); excp_req = 1'b0; settle();
    chk("t3_ops_switched", 64'({op1, op2}), {32'h100, 32'h0});
    chk("t3_req_held", 64'({req, kill, excp_ack}), 64'b100);
    cyc(); pipe_ack = 1'b1; settle();
    chk("t3_pulse", 64'({req, pulse}), 64'b11);
    cyc(); pipe_ack = 1'b0; settle();
    chk("t3_cnts", 64'({excp_cnt, brch_cnt}), {16'h1, 16'h0});
    cyc();

    // preempt collision with IFU ack
    cyc(); brch_req = 1'b1; brch_op1 = 32'h500; brch_op2 = 32'h14; settle();
    chk("t4_brch_ack", 64'(brch_ack), 64'h1);
    cyc(); brch_req = 1'b0; settle();
    chk("t4_req", 64'(req), 64'h1);
    cyc(); excp_req = 1'b1; excp_op1 = 32'h600; excp_op2 = 32'h18; pipe_ack = 1'b1; settle();
    chk("t4_no_excp_ack", 64'(excp_ack), 64'h0);
    chk("t4_no_kill", 64'(kill), 64'h0);
    chk("t4_pulse", 64'(pulse), 64'h1);
    cyc(); pipe_ack = 1'b0; settle();
    chk("t4_gap_no_ack", 64'({busy, excp_ack}), 64'b10);
    chk("t4_brch_counted", 64'({excp_cnt, brch_cnt}), {16'h1, 16'h1});
    cyc(); settle();
    chk("t4_excp_ack_late", 64'(excp_ack), 64'h1);
    cyc(); excp_req = 1'b0; pipe_ack = 1'b1; settle();
    chk("t4_excp_ops", 64'({op1, op2}), {32'h600, 32'h18});
    chk("t4_excp_pulse", 64'(pulse), 64'h1);
    cyc(); pipe_ack = 1'b0; settle();
    chk("t4_cnts", 64'({excp_cnt, brch_cnt}), {16'h2, 16'h1});
    cyc();

    // counter saturation and clear (4-bit copy saturates at 0xF)
    clear_cnts();
    chk("t5_sat_clr", 64'({s_excp_cnt, s_brch_cnt}), 64'h0);
    for (int i = 0; i < 15; i++) begin
      brch_flush(1'b0);
    end
    chk("t5_sat_full", 64'(s_brch_cnt), 64'hF);
    chk("t5_main_15", 64'(brch_cnt), 64'd15);
    brch_flush(1'b0);
    chk("t5_sat_hold", 64'(s_brch_cnt), 64'hF);
    chk("t5_main_16", 64'(brch_cnt), 64'd16);
    brch_flush(1'b1);
    chk("t5_sat_cleared", 64'({s_excp_cnt, s_brch_cnt}), 64'h0);
    chk("t5_main_cleared", 64'({excp_cnt, brch_cnt}), 64'h0);

    // reset mid-REQ
    brch_flush(1'b0);
    chk("t6_pre_cnt", 64'(brch_cnt), 64'h1);
    cyc(); brch_req = 1'b1; brch_op1 = 32'h900; brch_op2 = 32'h24; settle();
    chk("t6_brch_ack", 64'(brch_ack), 64'h1);
    cyc(); brch_req = 1'b0; settle();
    chk("t6_req", 64'(req), 64'h1);
    cyc(); rst_n = 1'b0; settle();
    chk("t6_no_pulse_in_rst", 64'(pulse), 64'h0);
    cyc(); rst_n = 1'b1; pipe_ack = 1'b1; settle();
    chk("t6_req_dropped", 64'(req), 64'h0);
    chk("t6_busy", 64'(busy), 64'h0);
    chk("t6_cnts", 64'({excp_cnt, brch_cnt}), 64'h0);
    chk("t6_no_pulse", 64'(pulse), 64'h0);
    chk("t6_ops", 64'({op1, op2}), 64'h0);
    cyc(); pipe_ack = 1'b0; settle();
    chk("t6_still_idle", 64'({req, busy}), 64'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
